if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, directly upstream of operand fetch (OF).
- Owns the PC register and the word-addressed instruction memory.
- Registers the IF/OF latch (PC, IR, valid) that OF consumes.
- Applies branch redirects from EX and stalls from the OF interlock.
- Provides a boot-time load port, a small run-control FSM with halt detection, and fetch/bubble counters.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/if_stage_if.sv | 37 +++
 rtl/instr_mem.sv | 30 +++
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: widths, the bubble encoding,
// the opcode field location, the halt opcode and the fetch run-control state encoding.
package pipe_pkg;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned IMEM_DEPTH = 2 ** PC_W;
    localparam int unsigned CNT_W      = 16;

    // Opcode field of an instruction word.
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;

    localparam logic [INSTR_W-1:0]       NOP_INSTR = 32'h6800_0000;
    localparam logic [OPC_MSB-OPC_LSB:0] HALT_OPC  = 5'b11111;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } state_e;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INSTR_W-1:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Bundle of the fetch stage's control, boot-load and IF/OF latch signals.
// Suffixes are from the fetch stage's point of view.
//   slave  : used by if_stage (consumes *_i, drives *_o)
//   master : used by whoever drives the stage (EX/OF logic, boot loader, bench)
interface if_stage_if;
    import pipe_pkg::*;

    logic               start_i;
    logic               imem_we_i;
    logic [PC_W-1:0]    imem_waddr_i;
    logic [INSTR_W-1:0] imem_wdata_i;
    logic               stall_i;
    logic               is_branch_taken_i;
    logic [PC_W-1:0]    branch_pc_i;
    logic [PC_W-1:0]    pc_o;
    logic [PC_W-1:0]    if_of_pc_o;
    logic [INSTR_W-1:0] if_of_ir_o;
    logic               if_of_valid_o;
    logic [1:0]         state_o;
    logic [CNT_W-1:0]   fetch_count_o;
    logic [CNT_W-1:0]   bubble_count_o;

    modport slave (
        input  start_i, imem_we_i, imem_waddr_i, imem_wdata_i,
        input  stall_i, is_branch_taken_i, branch_pc_i,
        output pc_o, if_of_pc_o, if_of_ir_o, if_of_valid_o,
        output state_o, fetch_count_o, bubble_count_o
    );

    modport master (
        output start_i, imem_we_i, imem_waddr_i, imem_wdata_i,
        output stall_i, is_branch_taken_i, branch_pc_i,
        input  pc_o, if_of_pc_o, if_of_ir_o, if_of_valid_o,
        input  state_o, fetch_count_o, bubble_count_o
    );

endinterface

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: one synchronous write port, one
// combinational read port. Contents have no reset.
//   clk_i   : write clock
//   we_i    : write strobe
//   waddr_i : write word address
//   wdata_i : write data
//   raddr_i : read word address
//   rdata_o : read data (combinational)
module instr_mem
    import pipe_pkg::*;
(
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [PC_W-1:0]    waddr_i,
    input  logic [INSTR_W-1:0] wdata_i,
    input  logic [PC_W-1:0]    raddr_i,
    output logic [INSTR_W-1:0] rdata_o
);

    logic [INSTR_W-1:0] mem_q [IMEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, the instruction memory and the IF/OF
// latch; applies EX branch redirects and OF stalls; runs a BOOT/RUN/HALTED
// control FSM and counts fetched instructions and flush bubbles.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : if_stage_if.slave -- start pulse, boot-time imem write port,
//           stall/branch controls, PC, IF/OF latch, state and counters
module if_stage
    import pipe_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic       clk,
    input logic       reset,
    if_stage_if.slave bus
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    lpc_q, lpc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

    logic               mem_we;
    logic [INSTR_W-1:0] fetched;
    logic               halt_req;

    // Loading is only allowed while booting.
    assign mem_we = (state_q == StBoot) && bus.imem_we_i;

    instr_mem u_imem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (bus.imem_waddr_i),
        .wdata_i (bus.imem_wdata_i),
        .raddr_i (pc_q),
        .rdata_o (fetched)
    );

    // A latched halt retires only when neither an older branch nor a stall
    // is pending this cycle.
    assign halt_req = valid_q && (opcode_of(ir_q) == HALT_OPC) &&
                      !bus.is_branch_taken_i && !bus.stall_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        lpc_d        = lpc_q;
        ir_d         = ir_q;
        valid_d      = valid_q;
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        unique case (state_q)
            StBoot: begin
                // The start edge itself does not fetch.
                if (bus.start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.is_branch_taken_i) begin
                    pc_d         = bus.branch_pc_i;
                    lpc_d        = pc_q;
                    ir_d         = NOP_INSTR;
                    valid_d      = 1'b0;
                    bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
                end else if (bus.stall_i) begin
                    // Hold everything.
                end else if (halt_req) begin
                    state_d = StHalted;
                    ir_d    = NOP_INSTR;
                    valid_d = 1'b0;
                end else begin
                    ir_d        = fetched;
                    valid_d     = 1'b1;
                    lpc_d       = pc_q;
                    pc_d        = pc_q + PC_W'(1);
                    fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
                end
            end
            StHalted: begin
                // Frozen until reset.
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StBoot;
            pc_q         <= RESET_PC;
            lpc_q        <= '0;
            ir_q         <= NOP_INSTR;
            valid_q      <= 1'b0;
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            lpc_q        <= lpc_d;
            ir_q         <= ir_d;
            valid_q      <= valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.pc_o           = pc_q;
    assign bus.if_of_pc_o     = lpc_q;
    assign bus.if_of_ir_o     = ir_q;
    assign bus.if_of_valid_o  = valid_q;
    assign bus.state_o        = state_q;
    assign bus.fetch_count_o  = fetch_cnt_q;
    assign bus.bubble_count_o = bubble_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed boot/branch/stall/halt/wrap/reset
// steps followed by a randomized run, all checked against a behavioural model.
module tb_if_stage;

    logic clk;
    logic reset;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] NOP  = 32'h6800_0000;
    localparam logic [31:0] HALT = 32'hF800_0000;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    logic [31:0] m_mem [1024];
    int unsigned m_pc, m_lpc, m_state, m_fetch, m_bub;
    logic [31:0] m_ir;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_lpc = 0; m_ir = NOP; m_valid = 1'b0;
        m_state = 0; m_fetch = 0; m_bub = 0;
    endtask

    // One clock edge of the fetch stage, from the behavioural rules.
    task automatic model_edge();
        if (m_state == 0) begin
            if (bus.imem_we_i) m_mem[bus.imem_waddr_i] = bus.imem_wdata_i;
            if (bus.start_i) m_state = 1;
        end else if (m_state == 1) begin
            if (bus.is_branch_taken_i) begin
                m_lpc = m_pc; m_ir = NOP; m_valid = 1'b0;
                m_pc = int'(bus.branch_pc_i);
                m_bub = (m_bub + 1) % 65536;
            end else if (bus.stall_i) begin
                // nothing moves
            end else if (m_valid && m_ir[31:27] == 5'b11111) begin
                m_state = 2; m_ir = NOP; m_valid = 1'b0;
            end else begin
                m_ir = m_mem[m_pc]; m_valid = 1'b1; m_lpc = m_pc;
                m_pc = (m_pc + 1) % 1024;
                m_fetch = (m_fetch + 1) % 65536;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " pc"},     32'(bus.pc_o),           m_pc);
        chk({tag, " lpc"},    32'(bus.if_of_pc_o),     m_lpc);
        chk({tag, " ir"},     bus.if_of_ir_o,          m_ir);
        chk({tag, " valid"},  32'(bus.if_of_valid_o),  32'(m_valid));
        chk({tag, " state"},  32'(bus.state_o),        m_state);
        chk({tag, " fetch"},  32'(bus.fetch_count_o),  m_fetch);
        chk({tag, " bubble"}, 32'(bus.bubble_count_o), m_bub);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic idle();
        bus.start_i = 1'b0; bus.imem_we_i = 1'b0; bus.imem_waddr_i = '0;
        bus.imem_wdata_i = '0; bus.stall_i = 1'b0; bus.is_branch_taken_i = 1'b0;
        bus.branch_pc_i = '0;
    endtask

    initial begin
        logic [31:0] word;
        idle();
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        #1;
        check_model("reset");
        chk("reset ir nop", bus.if_of_ir_o, NOP);
        chk("reset state", 32'(bus.state_o), 32'd0);
        #10 reset = 1'b1;

        // Boot: load all of imem; halts at 5 and 200, nothing else halts.
        for (int a = 0; a < 1024; a++) begin
            word = $urandom & 32'h7FFF_FFFF;
            if (a < 4) word = 32'(a + 1);
            if (a == 5 || a == 200) word = HALT;
            bus.imem_we_i = 1'b1; bus.imem_waddr_i = 10'(a); bus.imem_wdata_i = word;
            cycle("boot");
        end
        idle();
        bus.start_i = 1'b1;
        cycle("start");
        bus.start_i = 1'b0;
        chk("start state", 32'(bus.state_o), 32'd1);
        chk("start no fetch", 32'(bus.if_of_valid_o), 32'd0);

        // Linear fetch of 0..3.
        repeat (4) cycle("linear");
        chk("linear fetch cnt", 32'(bus.fetch_count_o), 32'd4);
        chk("linear ir", bus.if_of_ir_o, 32'd4);
        chk("linear lpc", 32'(bus.if_of_pc_o), 32'd3);
        chk("linear pc", 32'(bus.pc_o), 32'd4);

        // Branch wins over a simultaneous stall.
        bus.is_branch_taken_i = 1'b1; bus.branch_pc_i = 10'd100; bus.stall_i = 1'b1;
        cycle("branch");
        idle();
        chk("branch pc", 32'(bus.pc_o), 32'd100);
        chk("branch ir", bus.if_of_ir_o, NOP);
        chk("branch valid", 32'(bus.if_of_valid_o), 32'd0);
        chk("branch bubble", 32'(bus.bubble_count_o), 32'd1);
        chk("branch lpc", 32'(bus.if_of_pc_o), 32'd4);
        cycle("after branch");
        chk("target lpc", 32'(bus.if_of_pc_o), 32'd100);
        chk("target valid", 32'(bus.if_of_valid_o), 32'd1);

        // Stall for three edges, then resume at the held PC.
        bus.stall_i = 1'b1;
        repeat (3) cycle("stall");
        chk("stall pc", 32'(bus.pc_o), 32'd101);
        chk("stall fetch cnt", 32'(bus.fetch_count_o), 32'd5);
        bus.stall_i = 1'b0;
        cycle("resume");
        chk("resume lpc", 32'(bus.if_of_pc_o), 32'd101);

        // Write attempt while running must be dropped.
        bus.imem_we_i = 1'b1; bus.imem_waddr_i = 10'd1; bus.imem_wdata_i = 32'h1234_5678;
        cycle("run write");
        idle();

        // Halt squashed by a coinciding branch.
        bus.is_branch_taken_i = 1'b1; bus.branch_pc_i = 10'd200;
        cycle("to 200");
        idle();
        cycle("fetch halt 200");
        chk("halt200 ir", bus.if_of_ir_o, HALT);
        bus.is_branch_taken_i = 1'b1; bus.branch_pc_i = 10'd1023;
        cycle("squash halt");
        idle();
        chk("squash state", 32'(bus.state_o), 32'd1);
        chk("squash pc", 32'(bus.pc_o), 32'd1023);

        // PC wraps 1023 -> 0, then fetch 0..5.
        cycle("wrap");
        chk("wrap pc", 32'(bus.pc_o), 32'd0);
        cycle("fetch 0");
        cycle("fetch 1");
        chk("run write ignored", bus.if_of_ir_o, 32'd2);
        repeat (4) cycle("to halt");
        chk("halt lpc", 32'(bus.if_of_pc_o), 32'd5);

        // Halt waits out a stall.
        bus.stall_i = 1'b1;
        repeat (2) cycle("halt stalled");
        chk("halt stalled state", 32'(bus.state_o), 32'd1);
        bus.stall_i = 1'b0;
        cycle("halt");
        chk("halt state", 32'(bus.state_o), 32'd2);
        chk("halt valid", 32'(bus.if_of_valid_o), 32'd0);
        chk("halt pc", 32'(bus.pc_o), 32'd6);

        // Halted ignores everything.
        repeat (6) begin
            bus.stall_i = 1'($urandom_range(0, 1));
            bus.is_branch_taken_i = 1'($urandom_range(0, 1));
            bus.branch_pc_i = 10'($urandom_range(0, 1023));
            bus.start_i = 1'($urandom_range(0, 1));
            cycle("halted");
        end
        idle();

        // Reset out of HALTED, reload without halt words, random run.
        #3 reset = 1'b0;
        model_reset();
        #1;
        check_model("reset halted");
        #2 reset = 1'b1;
        bus.imem_we_i = 1'b1; bus.imem_waddr_i = 10'd5; bus.imem_wdata_i = 32'h0000_0055;
        cycle("reload5");
        bus.imem_waddr_i = 10'd200; bus.imem_wdata_i = 32'h0000_0200;
        cycle("reload200");
        idle();
        bus.start_i = 1'b1;
        cycle("restart");
        bus.start_i = 1'b0;
        for (int i = 0; i < 400; i++) begin
            bus.stall_i = ($urandom_range(0, 9) < 3);
            bus.is_branch_taken_i = ($urandom_range(0, 9) < 1);
            bus.branch_pc_i = 10'($urandom_range(0, 1023));
            bus.imem_we_i = 1'($urandom_range(0, 1));
            bus.imem_waddr_i = 10'($urandom_range(0, 1023));
            bus.imem_wdata_i = $urandom;
            cycle("random");
        end
        idle();

        // Asynchronous reset between edges while running.
        #3 reset = 1'b0;
        model_reset();
        #1;
        check_model("async reset");
        chk("async state", 32'(bus.state_o), 32'd0);
        chk("async ir", bus.if_of_ir_o, NOP);
        #2 reset = 1'b1;
        bus.start_i = 1'b1;
        cycle("reboot");
        bus.start_i = 1'b0;
        cycle("retain 0");
        chk("retain word0", bus.if_of_ir_o, 32'd1);
        repeat (7) cycle("retain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
